// File: rtl/dircc_output_arbiter.sv
// dircc_output_arbiter: packet-level round-robin arbiter for one DiRCC router output port
// Ports: clk_clk, reset_reset (synchronous, active-high); in_* are NUM_INPUTS packed Avalon-ST
// sinks with requester i at slice i; out_* is the shared Avalon-ST source; grant is the one-hot
// packet owner, busy is high while a packet is locked, drop_count saturates at 255 discarded beats.
module dircc_output_arbiter #(
    parameter int NUM_INPUTS  = 5,
    parameter int DATA_WIDTH  = 32,
    parameter int EMPTY_WIDTH = 2
) (
    input  logic                              clk_clk,
    input  logic                              reset_reset,
    input  logic [NUM_INPUTS*DATA_WIDTH-1:0]  in_data,
    input  logic [NUM_INPUTS-1:0]             in_valid,
    output logic [NUM_INPUTS-1:0]             in_ready,
    input  logic [NUM_INPUTS-1:0]             in_startofpacket,
    input  logic [NUM_INPUTS-1:0]             in_endofpacket,
    input  logic [NUM_INPUTS*EMPTY_WIDTH-1:0] in_empty,
    output logic [DATA_WIDTH-1:0]             out_data,
    output logic                              out_valid,
    input  logic                              out_ready,
    output logic                              out_startofpacket,
    output logic                              out_endofpacket,
    output logic [EMPTY_WIDTH-1:0]            out_empty,
    output logic [NUM_INPUTS-1:0]             grant,
    output logic                              busy,
    output logic [7:0]                        drop_count
);
    localparam int         IDX_W  = NUM_INPUTS > 1 ? $clog2(NUM_INPUTS) : 1;
    localparam logic [0:0] IDLE   = 1'b0;
    localparam logic [0:0] LOCKED = 1'b1;
    logic [0:0]            r_state;
    logic [NUM_INPUTS-1:0] r_grant;
    logic [IDX_W-1:0]      r_idx;
    logic [IDX_W-1:0]      r_rr_ptr;
    logic [7:0]            r_drop_count;
    logic [IDX_W-1:0]      w_sel;
    logic [IDX_W-1:0]      w_next_ptr;
    logic [NUM_INPUTS-1:0] w_cand;
    logic [NUM_INPUTS-1:0] w_drop;
    logic                  w_found;
    logic                  w_done;
    logic [15:0]           w_drop_sum;

    assign busy              = r_state == LOCKED;
    assign grant             = r_grant;
    assign drop_count        = r_drop_count;
    assign w_cand            = in_valid & in_startofpacket;
    // Orphan beats (no SOP) are swallowed only while no packet owns the port.
    assign w_drop            = busy ? '0 : in_valid & ~in_startofpacket;
    assign out_valid         = busy & in_valid[r_idx];
    assign out_startofpacket = busy & in_startofpacket[r_idx];
    assign out_endofpacket   = busy & in_endofpacket[r_idx];
    assign out_data          = busy ? in_data[r_idx*DATA_WIDTH +: DATA_WIDTH] : '0;
    assign out_empty         = busy ? in_empty[r_idx*EMPTY_WIDTH +: EMPTY_WIDTH] : '0;
    assign in_ready          = busy ? (out_ready ? r_grant : '0) : w_drop;
    assign w_done            = out_valid & out_ready & out_endofpacket;
    assign w_next_ptr        = r_idx == IDX_W'(NUM_INPUTS - 1) ? '0 : r_idx + 1'b1;

    // Scan from the farthest offset down so the candidate nearest rr_ptr is written last and wins.
    always_comb begin
        w_found = 1'b0;
        w_sel   = '0;
        for (int k = NUM_INPUTS - 1; k >= 0; k--) begin
            if (w_cand[(int'(r_rr_ptr) + k) % NUM_INPUTS]) begin
                w_found = 1'b1;
                w_sel   = IDX_W'((int'(r_rr_ptr) + k) % NUM_INPUTS);
            end
        end
    end

    always_comb begin
        w_drop_sum = 16'(r_drop_count);
        for (int i = 0; i < NUM_INPUTS; i++)
            w_drop_sum = w_drop_sum + 16'(w_drop[i]);
    end

    always_ff @(posedge clk_clk) begin
        if (reset_reset) begin
            r_state      <= IDLE;
            r_grant      <= '0;
            r_idx        <= '0;
            r_rr_ptr     <= '0;
            r_drop_count <= '0;
        end else if (busy) begin
            if (w_done) begin
                r_state  <= IDLE;
                r_grant  <= '0;
                r_rr_ptr <= w_next_ptr;
            end
        end else begin
            r_drop_count <= w_drop_sum > 16'd255 ? 8'hFF : w_drop_sum[7:0];
            if (w_found) begin
                r_state <= LOCKED;
                r_grant <= NUM_INPUTS'(1) << w_sel;
                r_idx   <= w_sel;
            end
        end
    end
endmodule

// File: doc/dircc_output_arbiter.md
# dircc_output_arbiter

Packet-level round-robin arbiter for one DiRCC router output port. Shares a single Avalon-ST output (east, west, north, south or here) between up to NUM_INPUTS router input ports. Grants one input per packet, holds the grant from startofpacket to endofpacket, then rotates priority. Beats arriving without a packet grant and without startofpacket are discarded and counted.

## Interface
- NUM_INPUTS, 5, number of requesting input ports; index 0..NUM_INPUTS-1
- DATA_WIDTH, 32, Avalon-ST data width
- EMPTY_WIDTH, 2, Avalon-ST empty width
- clk_clk  in  1  single clock; all logic on rising edge
- reset_reset  in  1  synchronous, active-high reset
- in_data  in  NUM_INPUTS*DATA_WIDTH  packed input data; requester i at [i*DATA_WIDTH +: DATA_WIDTH]
- in_valid  in  NUM_INPUTS  per-requester valid
- in_ready  out  NUM_INPUTS  per-requester ready
- in_startofpacket  in  NUM_INPUTS  per-requester SOP
- in_endofpacket  in  NUM_INPUTS  per-requester EOP
- in_empty  in  NUM_INPUTS*EMPTY_WIDTH  packed empty, same packing as data
- out_data  out  DATA_WIDTH  granted data
- out_valid  out  1  granted valid
- out_ready  in  1  downstream ready
- out_startofpacket  out  1
- out_endofpacket  out  1
- out_empty  out  EMPTY_WIDTH
- grant  out  NUM_INPUTS  registered one-hot grant; all zero when idle
- busy  out  1  high in LOCKED
- drop_count  out  8  saturating count of discarded beats

## Operation
- FSM states: IDLE, LOCKED. Registered: state, grant, rr_ptr (index of highest-priority requester), drop_count.
- IDLE: candidate i = in_valid[i] & in_startofpacket[i]. Select the first candidate scanning rr_ptr, rr_ptr+1, … wrapping modulo NUM_INPUTS. If one exists: next state LOCKED, grant <= onehot(selected). No data transferred in IDLE.
- IDLE discard: any requester with in_valid=1 and in_startofpacket=0 gets in_ready=1 in that cycle; the beat is dropped and drop_count increments by the number of such beats, saturating at 255. Candidates (SOP high) get in_ready=0 in IDLE.
- LOCKED, granted index g: out_* = in_*[g] combinationally; in_ready[g] = out_ready; in_ready of all other requesters = 0. No discard in LOCKED.
- Transfer = out_valid & out_ready. Transfer with out_endofpacket=1: next state IDLE, grant <= 0, rr_ptr <= (g+1) mod NUM_INPUTS.
- SOP on a non-first beat of the granted packet is forwarded unchanged. The arbiter does not check for it.
- Single-beat packets (SOP and EOP together) are legal: lock one cycle, transfer, return to IDLE.
- If out_valid is low in LOCKED, the arbiter holds the grant indefinitely. There is no timeout.

## Timing
- Reset: state IDLE, grant 0, busy 0, rr_ptr 0, drop_count 0. While idle, out_valid, out_startofpacket and out_endofpacket are 0, and out_data and out_empty are 0. All in_ready are 0 except the discard case.
- Reset asserted mid-packet: the next cycle is IDLE with every value above. The packet remainder from the old grantee is then treated as non-SOP beats and discarded.
- Latency: request seen in cycle N (IDLE), grant visible in cycle N+1, first beat can transfer in N+1.
- Zero-latency combinational path in LOCKED from in_valid[g] to out_valid and from out_ready to in_ready[g]. Follows Avalon-ST readyLatency 0.
- One idle bubble between back-to-back packets: the EOP transfer in cycle M is followed by IDLE in M+1 and the next grant in M+2.
- Simultaneous requests are resolved by rr_ptr only. A starved requester waits at most NUM_INPUTS-1 packets.
- drop_count updates on the cycle after the discarded beat.

## Test plan
- Reset, then in_valid=0: grant=0, busy=0, out_valid=0, in_ready=0, drop_count=0 for 10 cycles.
- Requester 2 sends a 3-beat packet (0xA1, 0xA2, 0xA3, empty=2 on the last beat) with out_ready=1: grant=5'b00100 one cycle after the request. out_data carries 0xA1..0xA3 on consecutive cycles and out_empty=2 with EOP. Next cycle IDLE, rr_ptr=3.
- All 5 requesters hold 1-beat packets continuously starting from reset: grants follow order 0,1,2,3,4,0 with one bubble cycle between each.
- Requester 1 is locked and out_ready toggles 1,0,0,1 through a 4-beat packet: each beat is held stable until accepted, and requester 3 (valid+SOP) sees in_ready=0 throughout.
- Requester 4 in IDLE presents 3 beats without SOP: in_ready[4]=1 on each beat, out_valid=0, drop_count=3. A further 300 such beats leave drop_count=255.
- Reset pulsed on the 2nd beat of a 4-beat packet from requester 0: next cycle grant=0, busy=0, rr_ptr=0. The remaining 2 beats are discarded and drop_count=2.
